crtc_mode_loader: RTL and testbench
===================================

Name: crtc_mode_loader

Overview:
Sequences a complete 16-register programming of the UM6845R from an internal preset table, on request from the OSD/core menu. It shares the CRTC register port with the Z80. Loads can be aligned to VSYNC to avoid tearing. After a load it restores the CPU's last-selected CRTC address, so CPU software sees no side effect.

Parameters:
WAIT_VSYNC, 1, 1 = hold the load until the rising edge of VSYNC; 0 = start immediately.
RESTORE_ADDR, 1, 1 = rewrite the CPU's shadowed address-register value after the load.

Ports:
CLOCK  in  1  system clock, the same clock as the CRTC.
nRESET  in  1  asynchronous active-low reset.
load_req  in  1  single-cycle pulse that requests a preset load.
load_sel  in  1  preset index; sampled on the load_req cycle.
VSYNC  in  1  CRTC VSYNC output.
cpu_en  in  1  CPU ENABLE to the CRTC.
cpu_ncs  in  1  CPU nCS to the CRTC.
cpu_rnw  in  1  CPU R_nW to the CRTC.
cpu_rs  in  1  CPU RS to the CRTC.
cpu_di  in  8  CPU write data.
crtc_en  out  1  ENABLE to the CRTC.
crtc_ncs  out  1  nCS to the CRTC.
crtc_rnw  out  1  R_nW to the CRTC.
crtc_rs  out  1  RS to the CRTC.
crtc_di  out  8  DI to the CRTC.
busy  out  1  high from the accepted load_req until done.
done  out  1  one-cycle pulse when the load completes.
cpu_wait  out  1  wait request to the CPU while the loader owns the port.

Behaviour:
- Reset (async, nRESET=0):
  - state=IDLE; busy=0, done=0, cpu_wait=0.
  - Index register = 0; shadow address = 0.
  - Outputs pass the CPU signals through.
- Preset table (register 0..15):
  - Preset 0: 63, 40, 46, 0x8E, 38, 0, 25, 30, 0, 7, 0, 0, 0x30, 0, 0, 0.
  - Preset 1 differs from preset 0 only in: R1=48, R2=50, R6=34, R7=35, R12=0x0C.
- Shadow address:
  - Updated to cpu_di[4:0] on every CPU select write (cpu_en & ~cpu_ncs & ~cpu_rnw & ~cpu_rs), in every state.
- Port mux:
  - In IDLE, WAIT_VS and DONE, crtc_* = cpu_* combinationally.
  - In SEL, DATA and RESTORE, the loader drives crtc_*.
  - A loader-driven cycle is a write: crtc_en=1, crtc_ncs=0, crtc_rnw=0.
  - A loader idle cycle drives crtc_en=0, crtc_ncs=1, crtc_rnw=1.
- Arbitration:
  - A CPU access (cpu_en & ~cpu_ncs) in a SEL, DATA or RESTORE cycle wins: the CPU signals are passed through and the loader state does not advance (retry next cycle).
  - cpu_wait = busy & ~(state==DONE).
- FSM:
  - IDLE: on load_req, latch load_sel, idx=0, busy=1. Go to WAIT_VS if WAIT_VSYNC=1, else to SEL.
  - WAIT_VS: wait for a VSYNC rising edge, detected against VSYNC registered one cycle. A VSYNC already high on entry does not qualify. Then go to SEL.
  - SEL: drive rs=0, di={3'b0, idx}. Go to DATA.
  - DATA: drive rs=1, di=table[sel][idx]. If idx==15, go to RESTORE (RESTORE_ADDR=1) or DONE (RESTORE_ADDR=0). Otherwise idx++ and go to SEL.
  - RESTORE: drive rs=0, di={3'b0, shadow}. Go to DONE.
  - DONE: done=1 for one cycle; busy=0 at the next edge; go to IDLE.
- Cycle cost: a full load with no contention is 16×2 + 1 + 1 = 34 cycles from SEL entry to the done pulse.
- load_req while busy is ignored; the latched sel is not changed.
- Reset mid-load: immediate abort. Partially written registers are left as-is; no done pulse.
- A CPU select write during a load updates the shadow, so RESTORE writes the newest value.

Test Plan:
- WAIT_VSYNC=0, load_req with sel=0, no CPU traffic.
  - Required: 33 crtc write cycles; the CRTC's internal R0..R15 registers (read via hierarchical probe) equal the preset-0 values.
  - Required: done pulses exactly 34 cycles after SEL entry, and busy falls on the following edge.
- sel=1 → R1=48, R6=34, R12=0x0C; all other registers equal preset 0.
- CPU selects register 12 before the load.
  - Required: the final loader write is rs=0, di=0x0C.
  - Required: a subsequent CPU read with RS=1 returns R12=0x30 (preset 0).
- CPU access injected during the DATA cycle of idx=5.
  - Required: the CPU cycle is passed through and the DATA write for idx 5 is retried next cycle; the total load takes one extra cycle.
- WAIT_VSYNC=1, load_req issued while VSYNC=1.
  - Required: the load waits for the next VSYNC rising edge, and the first SEL write occurs the cycle after that edge.
- nRESET asserted at idx=7 → all outputs return to reset values immediately; no done pulse. A new load_req afterwards completes normally.

Source files
------------

// File: rtl/crtc_mode_loader.sv
// Programs all 16 UM6845R registers from a two-entry preset table over the
// shared CRTC port, optionally aligned to VSYNC, then restores the CPU's address.
module crtc_mode_loader #(
  parameter bit WAIT_VSYNC   = 1'b1,
  parameter bit RESTORE_ADDR = 1'b1
) (
  input  logic       CLOCK,
  input  logic       nRESET,
  input  logic       load_req,
  input  logic       load_sel,
  input  logic       VSYNC,
  input  logic       cpu_en,
  input  logic       cpu_ncs,
  input  logic       cpu_rnw,
  input  logic       cpu_rs,
  input  logic [7:0] cpu_di,
  output logic       crtc_en,
  output logic       crtc_ncs,
  output logic       crtc_rnw,
  output logic       crtc_rs,
  output logic [7:0] crtc_di,
  output logic       busy,
  output logic       done,
  output logic       cpu_wait,
  output logic [2:0] o_dbg_state
);

  // Port handshake: a CRTC access happens in any cycle with en=1 and ncs=0;
  // rnw=0 makes it a write, rs selects address (0) or data (1) register.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT_VS = 3'd1,
    S_SEL     = 3'd2,
    S_DATA    = 3'd3,
    S_RESTORE = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic       r_sel;
  logic [3:0] r_idx;
  logic [4:0] r_shadow;
  logic       r_vsync_q;
  logic       r_busy;

  logic       w_cpu_access;
  logic       w_cpu_sel_wr;
  logic       w_loader_phase;
  logic       w_drive;
  logic       w_vs_rise;

  function automatic logic [7:0] preset_value(input logic sel, input logic [3:0] idx);
    logic [7:0] v;
    case (idx)
      4'd0:    v = 8'd63;
      4'd1:    v = sel ? 8'd48 : 8'd40;
      4'd2:    v = sel ? 8'd50 : 8'd46;
      4'd3:    v = 8'h8E;
      4'd4:    v = 8'd38;
      4'd6:    v = sel ? 8'd34 : 8'd25;
      4'd7:    v = sel ? 8'd35 : 8'd30;
      4'd9:    v = 8'd7;
      4'd12:   v = sel ? 8'h0C : 8'h30;
      default: v = 8'd0;
    endcase
    return v;
  endfunction

  assign w_cpu_access   = cpu_en & ~cpu_ncs;
  assign w_cpu_sel_wr   = cpu_en & ~cpu_ncs & ~cpu_rnw & ~cpu_rs;
  assign w_loader_phase = (r_state == S_SEL) || (r_state == S_DATA) || (r_state == S_RESTORE);
  // The CPU always wins a contended cycle; the loader simply retries.
  assign w_drive        = w_loader_phase & ~w_cpu_access;
  assign w_vs_rise      = VSYNC & ~r_vsync_q;

  always_ff @(posedge CLOCK or negedge nRESET) begin
    if (!nRESET) begin
      r_state   <= S_IDLE;
      r_sel     <= 1'b0;
      r_idx     <= 4'd0;
      r_shadow  <= 5'd0;
      r_vsync_q <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_vsync_q <= VSYNC;
      if (w_cpu_sel_wr) r_shadow <= cpu_di[4:0];
      if (r_state == S_IDLE && load_req) begin
        r_sel  <= load_sel;
        r_idx  <= 4'd0;
        r_busy <= 1'b1;
      end else if (r_state == S_DATA && w_drive && r_idx != 4'd15) begin
        r_idx <= r_idx + 4'd1;
      end
      if (r_state == S_DONE) r_busy <= 1'b0;
    end
  end

  always_comb begin
    w_next   = r_state;
    crtc_en  = cpu_en;
    crtc_ncs = cpu_ncs;
    crtc_rnw = cpu_rnw;
    crtc_rs  = cpu_rs;
    crtc_di  = cpu_di;
    if (w_drive) begin
      crtc_en  = 1'b1;
      crtc_ncs = 1'b0;
      crtc_rnw = 1'b0;
    end
    case (r_state)
      S_IDLE: if (load_req) w_next = WAIT_VSYNC ? S_WAIT_VS : S_SEL;
      S_WAIT_VS: if (w_vs_rise) w_next = S_SEL;
      S_SEL: if (w_drive) begin
        crtc_rs = 1'b0;
        crtc_di = {4'b0, r_idx};
        w_next  = S_DATA;
      end
      S_DATA: if (w_drive) begin
        crtc_rs = 1'b1;
        crtc_di = preset_value(r_sel, r_idx);
        if (r_idx == 4'd15) w_next = RESTORE_ADDR ? S_RESTORE : S_DONE;
        else                w_next = S_SEL;
      end
      S_RESTORE: if (w_drive) begin
        crtc_rs = 1'b0;
        crtc_di = {3'b0, r_shadow};
        w_next  = S_DONE;
      end
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign busy        = r_busy;
  assign done        = (r_state == S_DONE);
  assign cpu_wait    = r_busy & (r_state != S_DONE);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_crtc_mode_loader.sv
// Bench for crtc_mode_loader: a CRTC register model on the shared port, a
// write-sequence scoreboard, and directed load / arbitration / reset scenarios.
module tb_crtc_mode_loader;

  logic       CLOCK = 1'b0;
  logic       nRESET = 1'b0;
  logic       load_req = 1'b0, load_sel = 1'b0, load_req_vs = 1'b0, VSYNC = 1'b0;
  logic       cpu_en = 1'b0, cpu_ncs = 1'b1, cpu_rnw = 1'b1, cpu_rs = 1'b0;
  logic [7:0] cpu_di = 8'h00;
  logic       crtc_en, crtc_ncs, crtc_rnw, crtc_rs, busy, done, cpu_wait;
  logic [7:0] crtc_di;
  logic [2:0] dbg_state;
  logic       vs_en, vs_ncs, vs_rnw, vs_rs, vs_busy, vs_done, vs_wait;
  logic [7:0] vs_di;
  logic [2:0] vs_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_count = 0;
  logic [8:0] exp_q[$];

  logic [4:0] crtc_addr = 5'd0;
  logic [7:0] crtc_regs [0:15];

  crtc_mode_loader #(.WAIT_VSYNC(1'b0), .RESTORE_ADDR(1'b1)) u_dut (
    .CLOCK(CLOCK), .nRESET(nRESET), .load_req(load_req), .load_sel(load_sel), .VSYNC(VSYNC),
    .cpu_en(cpu_en), .cpu_ncs(cpu_ncs), .cpu_rnw(cpu_rnw), .cpu_rs(cpu_rs), .cpu_di(cpu_di),
    .crtc_en(crtc_en), .crtc_ncs(crtc_ncs), .crtc_rnw(crtc_rnw), .crtc_rs(crtc_rs),
    .crtc_di(crtc_di), .busy(busy), .done(done), .cpu_wait(cpu_wait), .o_dbg_state(dbg_state)
  );

  crtc_mode_loader #(.WAIT_VSYNC(1'b1), .RESTORE_ADDR(1'b1)) u_dut_vs (
    .CLOCK(CLOCK), .nRESET(nRESET), .load_req(load_req_vs), .load_sel(1'b0), .VSYNC(VSYNC),
    .cpu_en(cpu_en), .cpu_ncs(cpu_ncs), .cpu_rnw(cpu_rnw), .cpu_rs(cpu_rs), .cpu_di(cpu_di),
    .crtc_en(vs_en), .crtc_ncs(vs_ncs), .crtc_rnw(vs_rnw), .crtc_rs(vs_rs),
    .crtc_di(vs_di), .busy(vs_busy), .done(vs_done), .cpu_wait(vs_wait), .o_dbg_state(vs_dbg)
  );

  // ---------------- clock / watchdog ----------------
  always #5 CLOCK = ~CLOCK;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks so far", n_checks);
    $fatal(1, "watchdog");
  end

  // ---------------- CRTC register model ----------------
  always @(posedge CLOCK) begin
    if (crtc_en && !crtc_ncs && !crtc_rnw) begin
      if (!crtc_rs) crtc_addr <= crtc_di[4:0];
      else if (crtc_addr < 5'd16) crtc_regs[crtc_addr[3:0]] <= crtc_di;
    end
  end

  // ---------------- helpers ----------------
  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic logic [7:0] exp_reg(input logic sel, input logic [3:0] r);
    logic [7:0] p0 [0:15];
    logic [7:0] v;
    p0 = '{8'd63, 8'd40, 8'd46, 8'h8E, 8'd38, 8'd0, 8'd25, 8'd30,
           8'd0, 8'd7, 8'd0, 8'd0, 8'h30, 8'd0, 8'd0, 8'd0};
    v = p0[r];
    if (sel) begin
      case (r)
        4'd1:    v = 8'd48;
        4'd2:    v = 8'd50;
        4'd6:    v = 8'd34;
        4'd7:    v = 8'd35;
        4'd12:   v = 8'h0C;
        default: v = p0[r];
      endcase
    end
    return v;
  endfunction

  // Expected loader write stream: 16 x (select, data) then the restore select.
  function automatic void push_load(input logic sel, input int nwr, input logic [4:0] sh);
    logic [8:0] seq[$];
    for (int i = 0; i < 16; i++) begin
      seq.push_back({1'b0, 4'b0, i[3:0]});
      seq.push_back({1'b1, exp_reg(sel, i[3:0])});
    end
    seq.push_back({1'b0, 3'b0, sh});
    for (int i = 0; i < nwr; i++) exp_q.push_back(seq[i]);
  endfunction

  function automatic void check_regs(input string tag, input logic sel);
    for (int r = 0; r < 16; r++)
      check($sformatf("%s_R%0d", tag, r), {24'd0, crtc_regs[r]}, {24'd0, exp_reg(sel, r[3:0])});
  endfunction

  // ---------------- driver tasks ----------------
  task automatic cpu_idle();
    cpu_en = 1'b0; cpu_ncs = 1'b1; cpu_rnw = 1'b1; cpu_rs = 1'b0; cpu_di = 8'h00;
  endtask

  task automatic cpu_write(input logic rs, input logic [7:0] d);
    @(posedge CLOCK); #1;
    cpu_en = 1'b1; cpu_ncs = 1'b0; cpu_rnw = 1'b0; cpu_rs = rs; cpu_di = d;
    exp_q.push_back({rs, d});
    @(posedge CLOCK); #1;
    cpu_idle();
  endtask

  task automatic cpu_read_data(input string name, input logic [7:0] exp);
    @(posedge CLOCK); #1;
    cpu_en = 1'b1; cpu_ncs = 1'b0; cpu_rnw = 1'b1; cpu_rs = 1'b1;
    @(negedge CLOCK);
    check({name, "_ctl"}, {28'd0, crtc_en, crtc_ncs, crtc_rnw, crtc_rs}, 32'hB);
    check(name, {24'd0, crtc_regs[crtc_addr[3:0]]}, {24'd0, exp});
    @(posedge CLOCK); #1;
    cpu_idle();
  endtask

  // Leaves the caller in the first cycle after load_req (SEL when not waiting on VSYNC).
  task automatic pulse_load(input logic sel);
    @(posedge CLOCK); #1;
    load_req = 1'b1; load_sel = sel;
    @(posedge CLOCK); #1;
    load_req = 1'b0; load_sel = ~sel;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (cyc < 200) begin
      @(negedge CLOCK);
      cyc++;
      if (done) break;
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge CLOCK) begin
    logic [8:0] e;
    if (nRESET && crtc_en && !crtc_ncs && !crtc_rnw) begin
      wr_count++;
      if (exp_q.size() == 0) begin
        check("unexpected_write", {23'd0, crtc_rs, crtc_di}, 32'h1FF);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("write_%0d", wr_count), {23'd0, crtc_rs, crtc_di}, {23'd0, e});
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int cyc, wr0, ok, ndone;
    for (int r = 0; r < 16; r++) crtc_regs[r] = 8'h00;

    // Reset state and pass-through
    cpu_idle();
    repeat (3) @(posedge CLOCK);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_wait", {31'd0, cpu_wait}, 32'd0);
    check("rst_state", {29'd0, dbg_state}, 32'd0);
    check("rst_vs_busy", {31'd0, vs_busy}, 32'd0);
    cpu_rs = 1'b1; cpu_di = 8'hA5; cpu_rnw = 1'b0;
    #1;
    check("rst_pass", {20'd0, crtc_en, crtc_ncs, crtc_rnw, crtc_rs, crtc_di}, {20'd0, 4'b0101, 8'hA5});
    cpu_idle();
    @(posedge CLOCK); #1;
    nRESET = 1'b1;
    repeat (2) @(posedge CLOCK);

    // Load preset 0, no CPU traffic, shadow still 0
    push_load(1'b0, 33, 5'd0);
    wr0 = wr_count;
    pulse_load(1'b0);
    wait_done(cyc);
    check("t1_done_latency", cyc, 34);
    check("t1_busy_at_done", {31'd0, busy}, 32'd1);
    check("t1_wait_at_done", {31'd0, cpu_wait}, 32'd0);
    check("t1_write_count", wr_count - wr0, 33);
    @(negedge CLOCK);
    check("t1_busy_fall", {31'd0, busy}, 32'd0);
    check("t1_done_fall", {31'd0, done}, 32'd0);
    check_regs("t1", 1'b0);

    // Load preset 1 with a load_req ignored mid-load
    push_load(1'b1, 33, 5'd0);
    pulse_load(1'b1);
    repeat (5) @(posedge CLOCK);
    #1; load_req = 1'b1; load_sel = 1'b0;
    @(posedge CLOCK); #1; load_req = 1'b0;
    wait_done(cyc);
    check("t2_done_latency", 6 + cyc, 34);
    check_regs("t2", 1'b1);

    // CPU selects R12 first; restore must re-select it
    cpu_write(1'b0, 8'd12);
    push_load(1'b0, 33, 5'd12);
    pulse_load(1'b0);
    wait_done(cyc);
    check("t3_done_latency", cyc, 34);
    check("t3_queue_empty", exp_q.size(), 0);
    @(negedge CLOCK);
    check("t3_crtc_addr", {27'd0, crtc_addr}, 32'd12);
    cpu_read_data("t3_read_r12", 8'h30);

    // CPU read injected in the DATA cycle of idx 5
    push_load(1'b1, 33, 5'd12);
    pulse_load(1'b1);
    repeat (11) @(posedge CLOCK);
    #1;
    cpu_en = 1'b1; cpu_ncs = 1'b0; cpu_rnw = 1'b1; cpu_rs = 1'b1;
    @(negedge CLOCK);
    check("t4_state_data", {29'd0, dbg_state}, 32'd3);
    check("t4_cpu_pass", {28'd0, crtc_en, crtc_ncs, crtc_rnw, crtc_rs}, 32'hB);
    check("t4_wait_held", {31'd0, cpu_wait}, 32'd1);
    @(posedge CLOCK); #1;
    cpu_idle();
    wait_done(cyc);
    check("t4_done_latency", 12 + cyc, 35);
    check_regs("t4", 1'b1);

    // Reset while in SEL of idx 7
    push_load(1'b0, 14, 5'd0);
    pulse_load(1'b0);
    repeat (14) @(posedge CLOCK);
    #1; nRESET = 1'b0;
    #1;
    check("t5_rst_busy", {31'd0, busy}, 32'd0);
    check("t5_rst_wait", {31'd0, cpu_wait}, 32'd0);
    check("t5_rst_done", {31'd0, done}, 32'd0);
    check("t5_rst_pass", {28'd0, crtc_en, crtc_ncs, crtc_rnw, crtc_rs}, 32'h6);
    check("t5_queue_empty", exp_q.size(), 0);
    @(posedge CLOCK); #1; nRESET = 1'b1;
    ndone = 0;
    repeat (40) begin
      @(negedge CLOCK);
      if (done) ndone++;
    end
    check("t5_no_done", ndone, 0);
    push_load(1'b1, 33, 5'd0);
    pulse_load(1'b1);
    wait_done(cyc);
    check("t5_reload_latency", cyc, 34);
    check_regs("t5", 1'b1);

    // WAIT_VSYNC instance: request while VSYNC already high
    @(posedge CLOCK); #1; VSYNC = 1'b1;
    repeat (2) @(posedge CLOCK);
    #1; load_req_vs = 1'b1;
    @(posedge CLOCK); #1; load_req_vs = 0;
    ok = 1;
    repeat (6) begin
      @(negedge CLOCK);
      if (vs_en || !vs_busy || !vs_wait) ok = 0;
    end
    check("t6_hold_vs_high", ok, 1);
    @(posedge CLOCK); #1; VSYNC = 1'b0;
    ok = 1;
    repeat (3) begin
      @(negedge CLOCK);
      if (vs_en) ok = 0;
    end
    check("t6_hold_vs_low", ok, 1);
    @(posedge CLOCK); #1; VSYNC = 1'b1;
    @(negedge CLOCK);
    check("t6_edge_cycle", {31'd0, vs_en}, 32'd0);
    @(negedge CLOCK);
    check("t6_first_sel", {20'd0, vs_en, vs_ncs, vs_rnw, vs_rs, vs_di}, {20'd0, 4'b1000, 8'h00});
    cyc = 1;
    while (cyc < 200 && !vs_done) begin
      @(negedge CLOCK);
      cyc++;
    end
    check("t6_done_latency", cyc, 34);

    repeat (3) @(posedge CLOCK);
    check("final_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
